// File: rtl/axis_byte_serializer.sv
// AXI-Stream downsizer: IN_BYTES-wide beats in, one kept byte per beat out.
// A single holding register feeds the output; null lanes are skipped.
module axis_byte_serializer #(
  parameter int IN_BYTES    = 4,
  parameter int TUSER_WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [8*IN_BYTES-1:0]   s_axis_tdata,
  input  logic [IN_BYTES-1:0]     s_axis_tkeep,
  input  logic                    s_axis_tlast,
  input  logic [TUSER_WIDTH-1:0]  s_axis_tuser,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [7:0]              m_axis_tdata,
  output logic                    m_axis_tlast,
  output logic [TUSER_WIDTH-1:0]  m_axis_tuser,
  output logic                    err_null_last
);

  logic [IN_BYTES-1:0][7:0]   data_q;
  logic [IN_BYTES-1:0]        rem_q;
  logic                       last_q;
  logic [TUSER_WIDTH-1:0]     user_q;
  logic                       err_q;

  logic [IN_BYTES-1:0]        low;
  logic [IN_BYTES-1:0][7:0]   lane_masked;
  logic                       rem_nz, rem_one_hot;
  logic                       in_hs, out_hs;

  // Isolate the lowest pending lane; lanes drain in ascending order.
  assign low         = rem_q & (~rem_q + IN_BYTES'(1));
  assign rem_nz      = (rem_q != '0);
  assign rem_one_hot = rem_nz && ((rem_q & (rem_q - IN_BYTES'(1))) == '0);

  genvar g;
  generate
    for (g = 0; g < IN_BYTES; g++) begin : g_lane
      assign lane_masked[g] = data_q[g] & {8{low[g]}};
    end
  endgenerate

  always_comb begin
    m_axis_tdata = '0;
    for (int i = 0; i < IN_BYTES; i++) m_axis_tdata = m_axis_tdata | lane_masked[i];
  end

  // Outputs are forced quiet while reset is asserted, before the registers clear.
  assign m_axis_tvalid = !rst && rem_nz;
  assign m_axis_tlast  = last_q && rem_one_hot;
  assign m_axis_tuser  = user_q;
  assign err_null_last = !rst && err_q;

  // Ready combinationally follows m_axis_tready when the final byte is draining.
  assign s_axis_tready = !rst && (!rem_nz || (m_axis_tready && rem_one_hot));

  assign in_hs  = s_axis_tvalid && s_axis_tready;
  assign out_hs = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      last_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      err_q <= in_hs && s_axis_tlast && (s_axis_tkeep == '0);
      if (in_hs) begin
        rem_q  <= s_axis_tkeep;
        last_q <= s_axis_tlast;
      end else if (out_hs) begin
        rem_q <= rem_q & ~low;
      end
    end
  end

  // Payload registers need no reset; rem_q alone qualifies them.
  always_ff @(posedge clk) begin
    if (in_hs) begin
      data_q <= s_axis_tdata;
      user_q <= s_axis_tuser;
    end
  end

endmodule

// File: tb/tb_axis_byte_serializer.sv
// Directed bench for axis_byte_serializer: inputs driven and outputs checked
// on the falling edge, one call to cyc() per clock.
module tb_axis_byte_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [31:0] s_axis_tdata = '0;
  logic [3:0]  s_axis_tkeep = '0;
  logic        s_axis_tlast = 1'b0;
  logic [0:0]  s_axis_tuser = '0;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tlast;
  logic [0:0]  m_axis_tuser;
  logic        err_null_last;

  int checks = 0;
  int errors = 0;

  axis_byte_serializer #(.IN_BYTES(4), .TUSER_WIDTH(1)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .err_null_last(err_null_last)
  );

  always #5 clk = ~clk;

  // One clock: drive inputs after the falling edge, check the settled outputs.
  task automatic cyc(input string tag, input bit r, input bit sv, input logic [31:0] d,
                     input logic [3:0] k, input bit sl, input bit su, input bit mr,
                     input bit ev, input logic [7:0] ed, input bit el, input bit eu,
                     input bit esr, input bit eerr);
    @(negedge clk);
    rst = r; s_axis_tvalid = sv; s_axis_tdata = d; s_axis_tkeep = k;
    s_axis_tlast = sl; s_axis_tuser = su; m_axis_tready = mr;
    #1;
    checks++;
    assert (m_axis_tvalid === ev) else begin
      errors++; $error("FAIL %s m_tvalid obs=%b exp=%b", tag, m_axis_tvalid, ev);
    end
    checks++;
    assert (s_axis_tready === esr) else begin
      errors++; $error("FAIL %s s_tready obs=%b exp=%b", tag, s_axis_tready, esr);
    end
    checks++;
    assert (err_null_last === eerr) else begin
      errors++; $error("FAIL %s err_null_last obs=%b exp=%b", tag, err_null_last, eerr);
    end
    if (ev) begin
      checks++;
      assert ({m_axis_tdata, m_axis_tlast, m_axis_tuser} === {ed, el, eu}) else begin
        errors++;
        $error("FAIL %s data/last/user obs=%h/%b/%b exp=%h/%b/%b", tag,
               m_axis_tdata, m_axis_tlast, m_axis_tuser, ed, el, eu);
      end
    end
  endtask

  initial begin
    //      tag      r sv data          keep  sl su mr  ev byte  el eu sr er
    cyc("rst0",      1, 0, 32'h0,       4'h0, 0, 0, 1,  0, 8'h00, 0, 0, 0, 0);
    cyc("rst1",      1, 0, 32'h0,       4'h0, 0, 0, 1,  0, 8'h00, 0, 0, 0, 0);
    cyc("rst_rel",   0, 0, 32'h0,       4'h0, 0, 0, 1,  0, 8'h00, 0, 0, 1, 0);

    // Full beat, single packet
    cyc("t1_in",     0, 1, 32'h44332211, 4'hF, 1, 0, 1,  0, 8'h00, 0, 0, 1, 0);
    cyc("t1_b0",     0, 0, 32'h0,        4'h0, 0, 0, 1,  1, 8'h11, 0, 0, 0, 0);
    cyc("t1_b1",     0, 0, 32'h0,        4'h0, 0, 0, 1,  1, 8'h22, 0, 0, 0, 0);
    cyc("t1_b2",     0, 0, 32'h0,        4'h0, 0, 0, 1,  1, 8'h33, 0, 0, 0, 0);
    cyc("t1_b3",     0, 0, 32'h0,        4'h0, 0, 0, 1,  1, 8'h44, 1, 0, 1, 0);
    cyc("t1_idle",   0, 0, 32'h0,        4'h0, 0, 0, 1,  0, 8'h00, 0, 0, 1, 0);

    // Back-to-back beats, no bubble between 44 and 55
    cyc("t2_in0",    0, 1, 32'h44332211, 4'hF, 0, 0, 1,  0, 8'h00, 0, 0, 1, 0);
    cyc("t2_b0",     0, 1, 32'h88776655, 4'hF, 1, 0, 1,  1, 8'h11, 0, 0, 0, 0);
    cyc("t2_b1",     0, 1, 32'h88776655, 4'hF, 1, 0, 1,  1, 8'h22, 0, 0, 0, 0);
    cyc("t2_b2",     0, 1, 32'h88776655, 4'hF, 1, 0, 1,  1, 8'h33, 0, 0, 0, 0);
    cyc("t2_b3",     0, 1, 32'h88776655, 4'hF, 1, 0, 1,  1, 8'h44, 0, 0, 1, 0);
    cyc("t2_b4",     0, 0, 32'h0,        4'h0, 0, 0, 1,  1, 8'h55, 0, 0, 0, 0);
    cyc("t2_b5",     0, 0, 32'h0,        4'h0, 0, 0, 1,  1, 8'h66, 0, 0, 0, 0);
    cyc("t2_b6",     0, 0, 32'h0,        4'h0, 0, 0, 1,  1, 8'h77, 0, 0, 0, 0);
    cyc("t2_b7",     0, 0, 32'h0,        4'h0, 0, 0, 1,  1, 8'h88, 1, 0, 1, 0);
    cyc("t2_idle",   0, 0, 32'h0,        4'h0, 0, 0, 1,  0, 8'h00, 0, 0, 1, 0);

    // Sparse beat keep=1010 with tuser=1
    cyc("t3_in",     0, 1, 32'hAABBCCDD, 4'hA, 1, 1, 1,  0, 8'h00, 0, 0, 1, 0);
    cyc("t3_b0",     0, 0, 32'h0,        4'h0, 0, 0, 1,  1, 8'hCC, 0, 1, 0, 0);
    cyc("t3_b1",     0, 0, 32'h0,        4'h0, 0, 0, 1,  1, 8'hAA, 1, 1, 1, 0);
    cyc("t3_idle",   0, 0, 32'h0,        4'h0, 0, 0, 1,  0, 8'h00, 0, 0, 1, 0);

    // Backpressure pattern 1,0,0,1,0,1,1
    cyc("t4_in",     0, 1, 32'h44332211, 4'hF, 1, 0, 1,  0, 8'h00, 0, 0, 1, 0);
    cyc("t4_r1",     0, 0, 32'h0,        4'h0, 0, 0, 1,  1, 8'h11, 0, 0, 0, 0);
    cyc("t4_r0a",    0, 0, 32'h0,        4'h0, 0, 0, 0,  1, 8'h22, 0, 0, 0, 0);
    cyc("t4_r0b",    0, 0, 32'h0,        4'h0, 0, 0, 0,  1, 8'h22, 0, 0, 0, 0);
    cyc("t4_r1b",    0, 0, 32'h0,        4'h0, 0, 0, 1,  1, 8'h22, 0, 0, 0, 0);
    cyc("t4_r0c",    0, 0, 32'h0,        4'h0, 0, 0, 0,  1, 8'h33, 0, 0, 0, 0);
    cyc("t4_r1c",    0, 0, 32'h0,        4'h0, 0, 0, 1,  1, 8'h33, 0, 0, 0, 0);
    cyc("t4_r1d",    0, 0, 32'h0,        4'h0, 0, 0, 1,  1, 8'h44, 1, 0, 1, 0);
    cyc("t4_idle",   0, 0, 32'h0,        4'h0, 0, 0, 1,  0, 8'h00, 0, 0, 1, 0);

    // Last byte stalled: ready must follow m_tready
    cyc("t4s_in",    0, 1, 32'h000000E1, 4'h1, 1, 0, 0,  0, 8'h00, 0, 0, 1, 0);
    cyc("t4s_hold",  0, 0, 32'h0,        4'h0, 0, 0, 0,  1, 8'hE1, 1, 0, 0, 0);
    cyc("t4s_go",    0, 0, 32'h0,        4'h0, 0, 0, 1,  1, 8'hE1, 1, 0, 1, 0);
    cyc("t4s_idle",  0, 0, 32'h0,        4'h0, 0, 0, 1,  0, 8'h00, 0, 0, 1, 0);

    // Null beat with tlast, then a normal beat
    cyc("t5_in",     0, 1, 32'h12345678, 4'h0, 1, 0, 1,  0, 8'h00, 0, 0, 1, 0);
    cyc("t5_err",    0, 0, 32'h0,        4'h0, 0, 0, 1,  0, 8'h00, 0, 0, 1, 1);
    cyc("t5_next",   0, 1, 32'h0000005A, 4'h1, 1, 0, 1,  0, 8'h00, 0, 0, 1, 0);
    cyc("t5_b0",     0, 0, 32'h0,        4'h0, 0, 0, 1,  1, 8'h5A, 1, 0, 1, 0);
    cyc("t5_idle",   0, 0, 32'h0,        4'h0, 0, 0, 1,  0, 8'h00, 0, 0, 1, 0);

    // Reset mid-packet after two bytes
    cyc("t6_in",     0, 1, 32'h44332211, 4'hF, 1, 0, 1,  0, 8'h00, 0, 0, 1, 0);
    cyc("t6_b0",     0, 0, 32'h0,        4'h0, 0, 0, 1,  1, 8'h11, 0, 0, 0, 0);
    cyc("t6_b1",     0, 0, 32'h0,        4'h0, 0, 0, 1,  1, 8'h22, 0, 0, 0, 0);
    cyc("t6_rst",    1, 0, 32'h0,        4'h0, 0, 0, 1,  0, 8'h00, 0, 0, 0, 0);
    cyc("t6_in2",    0, 1, 32'hDDCCBBAA, 4'hF, 1, 0, 1,  0, 8'h00, 0, 0, 1, 0);
    cyc("t6_c0",     0, 0, 32'h0,        4'h0, 0, 0, 1,  1, 8'hAA, 0, 0, 0, 0);
    cyc("t6_c1",     0, 0, 32'h0,        4'h0, 0, 0, 1,  1, 8'hBB, 0, 0, 0, 0);
    cyc("t6_c2",     0, 0, 32'h0,        4'h0, 0, 0, 1,  1, 8'hCC, 0, 0, 0, 0);
    cyc("t6_c3",     0, 0, 32'h0,        4'h0, 0, 0, 1,  1, 8'hDD, 1, 0, 1, 0);
    cyc("t6_idle",   0, 0, 32'h0,        4'h0, 0, 0, 1,  0, 8'h00, 0, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
